kb_led_ctrl: RTL and testbench
==============================

Name: kb_led_ctrl

Overview:
- Host-side sequencer for the shared PS/2 link. It drives the transmitter and receiver to send the keyboard "Set LEDs" command (0xED followed by an argument byte), and waits for the 0xFA acknowledge after each byte.
- It gates the receiver enable while transmitting, and handles resend (0xFE), timeout and retries.
- It filters ACK/resend bytes out of the scan stream, so the downstream key-code decoder only sees keyboard scan bytes.

Parameters:
- TIMEOUT_CYC, 1_000_000, ACK wait limit in clk cycles (20 ms at 50 MHz); counter width is clog2(TIMEOUT_CYC).
- MAX_RETRY, 3, resend attempts per byte before aborting.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- led_req  in  1  one-cycle request to update LEDs.
- led_val  in  3  {caps, num, scroll}; sampled when led_req is accepted.
- tx_idle  in  1  transmitter ready.
- tx_done_tick  in  1  transmitter finished a byte.
- tx_wr  out  1  one-cycle write strobe to the transmitter.
- tx_data  out  8  byte to send; held stable from the tx_wr cycle until tx_done_tick.
- rx_en  out  1  receiver enable.
- rx_done_tick  in  1  receiver byte strobe.
- rx_data  in  8  received byte.
- scan_tick  out  1  rx_done_tick with controller-consumed bytes removed.
- busy  out  1  a transaction is in progress.
- done_tick  out  1  transaction acknowledged.
- err_tick  out  1  transaction aborted.
- led_state  out  3  last LED value confirmed by the keyboard.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE, retry = 0, timer = 0.
  - tx_wr = 0, tx_data = 0x00, rx_en = 1.
  - busy = 0, done_tick = 0, err_tick = 0, scan_tick = 0, led_state = 3'b000.
- Constants: CMD_LED = 0xED, ACK = 0xFA, RESEND = 0xFE.
- Registered outputs: tx_wr, done_tick and err_tick are registered one-cycle pulses.
- scan_tick is combinational: scan_tick = rx_done_tick AND NOT consume, where consume = (state is WAIT_ACK1 or WAIT_ACK2) AND (rx_data is ACK or RESEND).
- rx_en = 0 in SEND1, TX1, SEND2 and TX2; rx_en = 1 otherwise.
- busy = 1 in every state except IDLE.
- FSM states and transitions:
  - IDLE: on led_req, latch led_val into arg_reg, set retry = 0, go to SEND1.
  - SEND1: wait for tx_idle = 1. Then pulse tx_wr with tx_data = 0xED and go to TX1.
  - TX1: on tx_done_tick, clear timer and go to WAIT_ACK1.
  - WAIT_ACK1:
    - rx ACK: set retry = 0 and go to SEND2.
    - rx RESEND or timer = TIMEOUT_CYC-1: if retry < MAX_RETRY, increment retry and go to SEND1; else go to ABORT.
    - Any other rx byte is passed through on scan_tick; the timer keeps running.
  - SEND2: same as SEND1 but tx_data = {5'b0, arg_reg} (bit2 caps, bit1 num, bit0 scroll). Go to TX2.
  - TX2: on tx_done_tick, clear timer and go to WAIT_ACK2.
  - WAIT_ACK2:
    - rx ACK: load led_state = arg_reg, pulse done_tick, go to IDLE.
    - Resend or timeout: resend the argument byte only (go to SEND2) under the same retry rule; exhaustion goes to ABORT.
  - ABORT: pulse err_tick, go to IDLE; led_state is unchanged.
- Latency: with an idle transmitter, tx_wr rises 2 cycles after led_req (IDLE to SEND1 transition, then the SEND1 output register).
- Boundary conditions:
  - led_req while busy is ignored, unless the optional feature below is compiled in.
  - ACK arriving in the same cycle as timer expiry: the ACK wins.
  - Timer saturates; it is cleared on every state entry.
  - tx_done_tick outside TX1/TX2 is ignored.
  - Reset mid-transaction returns to IDLE immediately with all reset values, and led_state returns to 000.

Optional Feature:
- KB_LED_PEND_EN defined:
  - A one-deep pending register captures led_req/led_val while busy; a newer request overwrites an older one.
  - On return to IDLE (after done or abort), a pending request starts a new transaction on the next cycle and the pending flag clears.
- KB_LED_PEND_EN undefined: requests made while busy are dropped.

Decomposition:
- Shared package ps2_pkg holds:
  - constants CMD_LED, ACK, RESEND, BRK (0xF0);
  - the state encoding typedef.
- One sub-module is natural: kb_timeout_ctr (clear/enable/expired), reused by other PS/2 handshakes.

Test Plan:
- led_req with led_val = 3'b101; bench transmitter completes, then returns 0xFA, 0xFA:
  - tx_data sequence is 0xED then 0x05;
  - done_tick is a single pulse;
  - led_state = 101.
- Reply 0xFE after 0xED, then 0xFA, 0xFA:
  - 0xED is sent twice, then 0x05;
  - done_tick asserts;
  - scan_tick never asserts for 0xFE/0xFA.
- No reply after the argument byte (TIMEOUT_CYC reduced to 100):
  - argument is sent 4 times total;
  - err_tick pulses;
  - led_state is unchanged.
- Scan byte 0x1C arrives during WAIT_ACK1, then 0xFA:
  - scan_tick pulses for 0x1C only;
  - the transaction proceeds.
- Second led_req (3'b010) while busy:
  - KB_LED_PEND_EN undefined: dropped.
  - KB_LED_PEND_EN defined: a second transaction runs and led_state ends at 010.
- Assert reset during TX2:
  - state returns to IDLE, rx_en = 1, busy = 0, led_state = 000;
  - no done_tick or err_tick pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 host constants and the LED-command sequencer state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ps2_pkg;

    localparam logic [7:0] CMD_LED = 8'hED;
    localparam logic [7:0] ACK     = 8'hFA;
    localparam logic [7:0] RESEND  = 8'hFE;
    localparam logic [7:0] BRK     = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND1,
        ST_TX1,
        ST_WAIT_ACK1,
        ST_SEND2,
        ST_TX2,
        ST_WAIT_ACK2,
        ST_ABORT
    } kb_led_state_t;

endpackage

// File: rtl/kb_timeout_ctr.sv
// Saturating wait timer for PS/2 handshakes: counts while en, cleared by clr.
// Latency: expired asserts on the TIMEOUT_CYC-th enabled cycle after clear.
// Backpressure: none; holds at the last count until cleared.
module kb_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/kb_led_ctrl.sv
// PS/2 "Set LEDs" sequencer: sends 0xED + arg, waits for 0xFA, retries on 0xFE/timeout.
// Latency: tx_wr 2 cycles after an accepted led_req with an idle transmitter.
// Backpressure: waits on tx_idle; led_req while busy dropped (queued one-deep with KB_LED_PEND_EN).
module kb_led_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       led_req,
    input  logic [2:0] led_val,
    input  logic       tx_idle,
    input  logic       tx_done_tick,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic       rx_en,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       scan_tick,
    output logic       busy,
    output logic       done_tick,
    output logic       err_tick,
    output logic [2:0] led_state
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    kb_led_state_t state_q, state_nxt;
    logic [RW-1:0] retry_q, retry_nxt;
    logic [2:0]    arg_q, arg_nxt;
    logic [2:0]    led_q, led_nxt;
    logic [7:0]    tx_data_q, tx_data_nxt;
    logic          tx_wr_q, tx_wr_nxt;
    logic          done_q, done_nxt;
    logic          err_q, err_nxt;
    logic          ack_rx, rsnd_rx, retry_ok, tmo, tmr_clr, tmr_en, consume;
    logic          start_req;
    logic [2:0]    start_val;

    kb_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmo)
    );

`ifdef KB_LED_PEND_EN
    logic       pend_vld_q;
    logic [2:0] pend_val_q;

    // A fresh request in IDLE beats a stale pending one.
    assign start_req = led_req || pend_vld_q;
    assign start_val = led_req ? led_val : pend_val_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld_q <= 1'b0;
            pend_val_q <= 3'b000;
        end else if (led_req && (state_q != ST_IDLE)) begin
            pend_vld_q <= 1'b1;
            pend_val_q <= led_val;
        end else if (state_q == ST_IDLE) begin
            pend_vld_q <= 1'b0;
        end
    end
`else
    assign start_req = led_req;
    assign start_val = led_val;
`endif

    assign tmr_en   = (state_q == ST_WAIT_ACK1) || (state_q == ST_WAIT_ACK2);
    assign tmr_clr  = (state_nxt != state_q);
    assign ack_rx   = rx_done_tick && (rx_data == ACK);
    assign rsnd_rx  = rx_done_tick && (rx_data == RESEND);
    assign retry_ok = (retry_q < RW'(MAX_RETRY));
    assign consume  = tmr_en && ((rx_data == ACK) || (rx_data == RESEND));

    always_comb begin
        state_nxt   = state_q;
        retry_nxt   = retry_q;
        arg_nxt     = arg_q;
        led_nxt     = led_q;
        tx_data_nxt = tx_data_q;
        tx_wr_nxt   = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    arg_nxt   = start_val;
                    retry_nxt = '0;
                    state_nxt = ST_SEND1;
                end
            end
            ST_SEND1: begin
                if (tx_idle) begin
                    tx_wr_nxt   = 1'b1;
                    tx_data_nxt = CMD_LED;
                    state_nxt   = ST_TX1;
                end
            end
            ST_TX1: begin
                if (tx_done_tick) state_nxt = ST_WAIT_ACK1;
            end
            ST_WAIT_ACK1: begin
                // ACK is tested first so it wins over a coincident timeout.
                if (ack_rx) begin
                    retry_nxt = '0;
                    state_nxt = ST_SEND2;
                end else if (rsnd_rx || tmo) begin
                    if (retry_ok) begin
                        retry_nxt = retry_q + RW'(1);
                        state_nxt = ST_SEND1;
                    end else begin
                        state_nxt = ST_ABORT;
                    end
                end
            end
            ST_SEND2: begin
                if (tx_idle) begin
                    tx_wr_nxt   = 1'b1;
                    tx_data_nxt = {5'b00000, arg_q};
                    state_nxt   = ST_TX2;
                end
            end
            ST_TX2: begin
                if (tx_done_tick) state_nxt = ST_WAIT_ACK2;
            end
            ST_WAIT_ACK2: begin
                if (ack_rx) begin
                    led_nxt   = arg_q;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (rsnd_rx || tmo) begin
                    if (retry_ok) begin
                        retry_nxt = retry_q + RW'(1);
                        state_nxt = ST_SEND2;
                    end else begin
                        state_nxt = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                err_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            retry_q   <= '0;
            arg_q     <= 3'b000;
            led_q     <= 3'b000;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            retry_q   <= retry_nxt;
            arg_q     <= arg_nxt;
            led_q     <= led_nxt;
            tx_data_q <= tx_data_nxt;
            tx_wr_q   <= tx_wr_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    assign tx_wr     = tx_wr_q;
    assign tx_data   = tx_data_q;
    assign done_tick = done_q;
    assign err_tick  = err_q;
    assign led_state = led_q;
    assign busy      = (state_q != ST_IDLE);
    assign rx_en     = !(state_q inside {ST_SEND1, ST_TX1, ST_SEND2, ST_TX2});
    assign scan_tick = rx_done_tick && !consume;

endmodule

// File: tb/tb_kb_led_ctrl.sv
// Bench for kb_led_ctrl: transmitter + keyboard responder driven from reply scripts,
// checked against a transaction-level model of the LED command exchange.
module tb_kb_led_ctrl;

    localparam int TMO  = 100;
    localparam int MAXR = 3;
    localparam int K_ACK = 0, K_RSND = 1, K_NONE = 2, K_SCAN = 3, K_LATE = 4;

    logic       clk = 1'b0, reset = 1'b1, led_req = 1'b0;
    logic [2:0] led_val = 3'b000;
    logic       tx_idle = 1'b1, tx_done_tick = 1'b0, rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_wr, rx_en, scan_tick, busy, done_tick, err_tick;
    logic [7:0] tx_data;
    logic [2:0] led_state;

    kb_led_ctrl #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .reset(reset), .led_req(led_req), .led_val(led_val),
        .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_wr(tx_wr), .tx_data(tx_data),
        .rx_en(rx_en), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .scan_tick(scan_tick), .busy(busy), .done_tick(done_tick), .err_tick(err_tick),
        .led_state(led_state)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int scr_kind[$];
    logic [7:0] scr_scan[$];
    logic [7:0] sent_q[$], scan_q[$], exp_sent[$], exp_scan[$];
    int n_done = 0, n_err = 0, exp_done, exp_err;
    logic [2:0] exp_led = 3'b000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_scr(input int k, input logic [7:0] sb);
        scr_kind.push_back(k);
        scr_scan.push_back(sb);
    endtask

    task automatic clr_scr();
        scr_kind.delete();
        scr_scan.delete();
    endtask

    // Transaction-level expectation: one reply consumed per byte put on the wire.
    task automatic model(input logic [2:0] arg);
        int phase = 1, retry = 0, i = 0, k;
        exp_sent.delete(); exp_scan.delete();
        exp_done = 0; exp_err = 0;
        while (1) begin
            exp_sent.push_back(phase == 1 ? 8'hED : {5'b00000, arg});
            k = (i < scr_kind.size()) ? scr_kind[i] : K_NONE;
            if (k == K_SCAN) exp_scan.push_back(scr_scan[i]);
            i++;
            if (k == K_ACK || k == K_SCAN || k == K_LATE) begin
                if (phase == 1) begin
                    phase = 2; retry = 0;
                end else begin
                    exp_done = 1; exp_led = arg; break;
                end
            end else if (retry < MAXR) begin
                retry++;
            end else begin
                exp_err = 1; break;
            end
        end
        while (scr_kind.size() > i) begin
            void'(scr_kind.pop_back());
            void'(scr_scan.pop_back());
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_wr) sent_q.push_back(tx_data);
            if (scan_tick) scan_q.push_back(rx_data);
            if (done_tick) n_done++;
            if (err_tick) n_err++;
        end
    end

    // Transmitter plus keyboard: finish each written byte, then answer from the script.
    initial begin : kbd
        int kind, m;
        logic [7:0] sb, wb;
        forever begin
            @(negedge clk);
            if (tx_wr && !reset) begin
                wb = tx_data;
                tx_idle = 1'b0;
                repeat (3) @(negedge clk);
                if (busy) chk("tx_data_hold", tx_data, wb);
                tx_done_tick = 1'b1;
                @(negedge clk);
                tx_done_tick = 1'b0;
                tx_idle = 1'b1;
                kind = K_NONE; sb = 8'h00;
                if (scr_kind.size() > 0) begin
                    kind = scr_kind.pop_front();
                    sb = scr_scan.pop_front();
                end
                m = (kind == K_LATE) ? TMO : $urandom_range(2, 8);
                if (kind != K_NONE) begin
                    repeat (m - 1) @(negedge clk);
                    if (kind == K_SCAN) begin
                        rx_data = sb; rx_done_tick = 1'b1;
                        @(negedge clk);
                        rx_done_tick = 1'b0;
                        @(negedge clk);
                    end
                    rx_data = (kind == K_RSND) ? 8'hFE : 8'hFA;
                    rx_done_tick = 1'b1;
                    @(negedge clk);
                    rx_done_tick = 1'b0;
                end
            end
        end
    end

    task automatic run_txn(input logic [2:0] v, input string tag);
        bit fin = 0;
        model(v);
        @(negedge clk);
        sent_q.delete(); scan_q.delete(); n_done = 0; n_err = 0;
        led_val = v; led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
        chk({tag, "_lat_busy"}, busy, 1);
        chk({tag, "_lat_wr0"}, tx_wr, 0);
        chk({tag, "_lat_rx_en"}, rx_en, 0);
        @(negedge clk);
        chk({tag, "_lat_wr1"}, tx_wr, 1);
        chk({tag, "_lat_cmd"}, tx_data, 8'hED);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!busy && (n_done + n_err) > 0) begin fin = 1; break; end
        end
        chk({tag, "_finish"}, fin, 1);
        repeat (5) @(negedge clk);
        chk({tag, "_sent_n"}, sent_q.size(), exp_sent.size());
        for (int i = 0; i < exp_sent.size() && i < sent_q.size(); i++)
            chk({tag, "_sent_byte"}, sent_q[i], exp_sent[i]);
        chk({tag, "_done_n"}, n_done, exp_done);
        chk({tag, "_err_n"}, n_err, exp_err);
        chk({tag, "_led_state"}, led_state, exp_led);
        chk({tag, "_scan_n"}, scan_q.size(), exp_scan.size());
        for (int i = 0; i < exp_scan.size() && i < scan_q.size(); i++)
            chk({tag, "_scan_byte"}, scan_q[i], exp_scan[i]);
        chk({tag, "_idle_rx_en"}, rx_en, 1);
        clr_scr();
    endtask

    initial begin : main
        bit seen;
        int x;
        #12;
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_rx_en", rx_en, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_tick, 0);
        chk("rst_err", err_tick, 0);
        chk("rst_scan", scan_tick, 0);
        chk("rst_led", led_state, 3'b000);
        @(negedge clk);
        reset = 1'b0;

        add_scr(K_ACK, 0); add_scr(K_ACK, 0);
        run_txn(3'b101, "basic");
        add_scr(K_RSND, 0); add_scr(K_ACK, 0); add_scr(K_ACK, 0);
        run_txn(3'b101, "resend");
        add_scr(K_ACK, 0);
        for (int i = 0; i < 4; i++) add_scr(K_NONE, 0);
        run_txn(3'b011, "timeout");
        add_scr(K_SCAN, 8'h1C); add_scr(K_ACK, 0);
        run_txn(3'b110, "scan");
        add_scr(K_ACK, 0); add_scr(K_LATE, 0);
        run_txn(3'b010, "ack_vs_tmo");

        for (int r = 0; r < 12; r++) begin
            for (int j = 0; j < 10; j++) begin
                x = $urandom_range(0, 9);
                if (x < 5)       add_scr(K_ACK, 0);
                else if (x < 7)  add_scr(K_RSND, 0);
                else if (x == 7) add_scr(K_NONE, 0);
                else             add_scr(K_SCAN, 8'($urandom_range(1, 8'hEF)));
            end
            run_txn(3'($urandom_range(0, 7)), "rand");
        end

        // Request arriving while busy.
        for (int i = 0; i < 4; i++) add_scr(K_ACK, 0);
        @(negedge clk);
        sent_q.delete(); scan_q.delete(); n_done = 0; n_err = 0;
        led_val = 3'b001; led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tx_wr) begin seen = 1; break; end
        end
        chk("busy_first_wr", seen, 1);
        @(negedge clk);
        led_val = 3'b010; led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
`ifdef KB_LED_PEND_EN
        exp_sent = '{8'hED, 8'h01, 8'hED, 8'h02}; exp_done = 2; exp_led = 3'b010;
`else
        exp_sent = '{8'hED, 8'h01}; exp_done = 1; exp_led = 3'b001;
`endif
        seen = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!busy && n_done >= exp_done) begin seen = 1; break; end
        end
        chk("busy_finish", seen, 1);
        repeat (300) @(negedge clk);
        chk("busy_sent_n", sent_q.size(), exp_sent.size());
        for (int i = 0; i < exp_sent.size() && i < sent_q.size(); i++)
            chk("busy_sent_byte", sent_q[i], exp_sent[i]);
        chk("busy_done_n", n_done, exp_done);
        chk("busy_led_state", led_state, exp_led);
        clr_scr();

        // Reset while the argument byte is on the wire.
        add_scr(K_ACK, 0);
        @(negedge clk);
        led_val = 3'b111; led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (tx_wr && tx_data == 8'h07) begin seen = 1; break; end
        end
        chk("rst_mid_tx2_seen", seen, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rx_en", rx_en, 1);
        chk("rst_mid_led", led_state, 3'b000);
        chk("rst_mid_tx_wr", tx_wr, 0);
        chk("rst_mid_tx_data", tx_data, 8'h00);
        n_done = 0; n_err = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        chk("rst_mid_done_n", n_done, 0);
        chk("rst_mid_err_n", n_err, 0);
        chk("rst_mid_led_after", led_state, 3'b000);
        chk("rst_mid_busy_after", busy, 0);
        clr_scr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
